// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared types, video mode timings and decode helpers
package vga_timing_gen_pkg;

   // One raster sample as it travels through the output delay line.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } raster_t;

   localparam int RASTER_W = $bits(raster_t);

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs.
   localparam int M640_H_RES  = 640;
   localparam int M640_H_FP   = 16;
   localparam int M640_H_SYNC = 96;
   localparam int M640_H_BP   = 48;
   localparam int M640_V_RES  = 480;
   localparam int M640_V_FP   = 10;
   localparam int M640_V_SYNC = 2;
   localparam int M640_V_BP   = 33;
   localparam bit M640_H_POL  = 1'b0;
   localparam bit M640_V_POL  = 1'b0;

   // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
   localparam int M800_H_RES  = 800;
   localparam int M800_H_FP   = 40;
   localparam int M800_H_SYNC = 128;
   localparam int M800_H_BP   = 88;
   localparam int M800_V_RES  = 600;
   localparam int M800_V_FP   = 1;
   localparam int M800_V_SYNC = 4;
   localparam int M800_V_BP   = 23;
   localparam bit M800_H_POL  = 1'b1;
   localparam bit M800_V_POL  = 1'b1;

   // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs.
   localparam int M720_H_RES  = 1280;
   localparam int M720_H_FP   = 110;
   localparam int M720_H_SYNC = 40;
   localparam int M720_H_BP   = 220;
   localparam int M720_V_RES  = 720;
   localparam int M720_V_FP   = 5;
   localparam int M720_V_SYNC = 5;
   localparam int M720_V_BP   = 20;
   localparam bit M720_H_POL  = 1'b1;
   localparam bit M720_V_POL  = 1'b1;

   // Half-open window test lo <= val < hi on zero-extended counts.
   function automatic logic in_window(input int unsigned val,
                                      input int unsigned lo,
                                      input int unsigned hi);
      return (val >= lo) && (val < hi);
   endfunction

   // Raster value shown while blanked: no display, both syncs inactive.
   function automatic raster_t idle_raster(input bit h_pol, input bit v_pol);
      raster_t r;
      r.de = 1'b0;
      r.hs = ~h_pol;
      r.vs = ~v_pol;
      return r;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-qualified shift register with synchronous reset
module vga_delay_line #(
   parameter int                WIDTH   = 3,
   parameter int                DEPTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             ce_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("vga_delay_line: DEPTH must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Shift one stage per enabled pixel; hold everything otherwise.
   always_comb begin
      stage_d = stage_q;
      if (ce_i) begin
         stage_d[0] = din_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   // Stage registers; reset flushes every stage to the idle value.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel enable
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int HSZ    = 12,
   parameter int VSZ    = 11,
   parameter int H_RES  = M640_H_RES,
   parameter int H_FP   = M640_H_FP,
   parameter int H_SYNC = M640_H_SYNC,
   parameter int H_BP   = M640_H_BP,
   parameter int V_RES  = M640_V_RES,
   parameter int V_FP   = M640_V_FP,
   parameter int V_SYNC = M640_V_SYNC,
   parameter int V_BP   = M640_V_BP,
   parameter bit H_POL  = M640_H_POL,
   parameter bit V_POL  = M640_V_POL,
   parameter int LEAD   = 1
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           ce_i,
   output logic [HSZ-1:0] hcount_o,
   output logic [VSZ-1:0] vcount_o,
   output logic           de_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           line_start_o,
   output logic           frame_start_o,
   output logic           vblank_o
);

   localparam int H_TOTAL   = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_RES + V_FP + V_SYNC + V_BP;
   localparam int HS_START  = H_RES + H_FP;
   localparam int HS_END    = HS_START + H_SYNC;
   localparam int VS_START  = V_RES + V_FP;
   localparam int VS_END    = VS_START + V_SYNC;

   localparam logic [HSZ-1:0] H_LAST = HSZ'(H_TOTAL - 1);
   localparam logic [VSZ-1:0] V_LAST = VSZ'(V_TOTAL - 1);

   localparam raster_t IDLE = idle_raster(H_POL, V_POL);

   generate
      if (HSZ < $clog2(H_TOTAL)) begin : g_bad_hsz
         $error("vga_timing_gen: HSZ too narrow for H_TOTAL");
      end
      if (VSZ < $clog2(V_TOTAL)) begin : g_bad_vsz
         $error("vga_timing_gen: VSZ too narrow for V_TOTAL");
      end
      if ((LEAD < 1) || (LEAD > 8)) begin : g_bad_lead
         $error("vga_timing_gen: LEAD must be in 1..8");
      end
   endgenerate

   logic [HSZ-1:0] h_q, h_d;
   logic [VSZ-1:0] v_q, v_d;
   raster_t        raw;
   raster_t        dly;

   // Raster position: h steps each enabled pixel, v steps when h wraps.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (ce_i) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Counter registers; reset wins over the pixel enable.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Undelayed decode; vs depends on v only so it flips at the line boundary.
   always_comb begin
      raw    = IDLE;
      raw.de = in_window(32'(h_q), 32'(0), 32'(H_RES)) &&
               in_window(32'(v_q), 32'(0), 32'(V_RES));
      raw.hs = in_window(32'(h_q), 32'(HS_START), 32'(HS_END)) ? H_POL : ~H_POL;
      raw.vs = in_window(32'(v_q), 32'(VS_START), 32'(VS_END)) ? V_POL : ~V_POL;
   end

   // Align de/syncs LEAD pixels behind the counts so readers can prefetch.
   vga_delay_line #(
      .WIDTH   (RASTER_W),
      .DEPTH   (LEAD),
      .RST_VAL (IDLE)
   ) u_delay (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .ce_i    (ce_i),
      .din_i   (raw),
      .dout_o  (dly)
   );

   assign hcount_o = h_q;
   assign vcount_o = v_q;
   assign de_o     = dly.de;
   assign hsync_o  = dly.hs;
   assign vsync_o  = dly.vs;

   // Status strobes track the counts directly and are silenced in reset.
   always_comb begin
      line_start_o  = rst_n_i && ce_i && (h_q == '0);
      frame_start_o = rst_n_i && ce_i && (h_q == '0) && (v_q == '0);
      vblank_o      = rst_n_i && (32'(v_q) >= 32'(V_RES));
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

   typedef struct {
      int hres; int hfp; int hsync; int hbp;
      int vres; int vfp; int vsync; int vbp;
      int lead; int hpol; int vpol;
   } geom_t;

   localparam int A_HRES = 16, A_HFP = 2, A_HSYNC = 3, A_HBP = 4;
   localparam int A_VRES = 6,  A_VFP = 1, A_VSYNC = 2, A_VBP = 2;
   localparam int A_LEAD = 3;
   localparam int B_HRES = 10, B_HFP = 3, B_HSYNC = 4, B_HBP = 5;
   localparam int B_VRES = 5,  B_VFP = 2, B_VSYNC = 3, B_VBP = 1;
   localparam int B_LEAD = 1;

   geom_t ga, gb;

   logic clk = 1'b0;
   logic rst_n;
   logic ce;

   logic [4:0] hcount_a, hcount_b;
   logic [3:0] vcount_a, vcount_b;
   logic de_a, hsync_a, vsync_a, ls_a, fs_a, vb_a;
   logic de_b, hsync_b, vsync_b, ls_b, fs_b, vb_b;

   int n_checks = 0;
   int n_fail   = 0;
   int pix      = 0;
   bit started  = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .HSZ(5), .VSZ(4),
      .H_RES(A_HRES), .H_FP(A_HFP), .H_SYNC(A_HSYNC), .H_BP(A_HBP),
      .V_RES(A_VRES), .V_FP(A_VFP), .V_SYNC(A_VSYNC), .V_BP(A_VBP),
      .H_POL(1'b0), .V_POL(1'b0), .LEAD(A_LEAD)
   ) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce),
      .hcount_o(hcount_a), .vcount_o(vcount_a),
      .de_o(de_a), .hsync_o(hsync_a), .vsync_o(vsync_a),
      .line_start_o(ls_a), .frame_start_o(fs_a), .vblank_o(vb_a)
   );

   vga_timing_gen #(
      .HSZ(5), .VSZ(4),
      .H_RES(B_HRES), .H_FP(B_HFP), .H_SYNC(B_HSYNC), .H_BP(B_HBP),
      .V_RES(B_VRES), .V_FP(B_VFP), .V_SYNC(B_VSYNC), .V_BP(B_VBP),
      .H_POL(1'b1), .V_POL(1'b1), .LEAD(B_LEAD)
   ) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce),
      .hcount_o(hcount_b), .vcount_o(vcount_b),
      .de_o(de_b), .hsync_o(hsync_b), .vsync_o(vsync_b),
      .line_start_o(ls_b), .frame_start_o(fs_b), .vblank_o(vb_b)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int htot(input geom_t g);
      return g.hres + g.hfp + g.hsync + g.hbp;
   endfunction

   function automatic int vtot(input geom_t g);
      return g.vres + g.vfp + g.vsync + g.vbp;
   endfunction

   function automatic int pos_h(input geom_t g, input int m);
      return m % htot(g);
   endfunction

   function automatic int pos_v(input geom_t g, input int m);
      return (m / htot(g)) % vtot(g);
   endfunction

   // Delayed outputs show the decode of the pixel LEAD enabled steps ago,
   // or idle levels if fewer than LEAD pixels have elapsed since reset.
   function automatic int exp_de(input geom_t g, input int n);
      if (n < g.lead) return 0;
      return (pos_h(g, n - g.lead) < g.hres && pos_v(g, n - g.lead) < g.vres) ? 1 : 0;
   endfunction

   function automatic int exp_hs(input geom_t g, input int n);
      int h;
      if (n < g.lead) return 1 - g.hpol;
      h = pos_h(g, n - g.lead);
      return (h >= g.hres + g.hfp && h < g.hres + g.hfp + g.hsync) ? g.hpol : 1 - g.hpol;
   endfunction

   function automatic int exp_vs(input geom_t g, input int n);
      int v;
      if (n < g.lead) return 1 - g.vpol;
      v = pos_v(g, n - g.lead);
      return (v >= g.vres + g.vfp && v < g.vres + g.vfp + g.vsync) ? g.vpol : 1 - g.vpol;
   endfunction

   task automatic check_dut(input string t, input geom_t g, input int hc, input int vc,
                            input int de, input int hs, input int vs,
                            input int ls, input int fs, input int vb);
      int h, v, live;
      h    = pos_h(g, pix);
      v    = pos_v(g, pix);
      live = (rst_n === 1'b1 && ce === 1'b1) ? 1 : 0;
      chk({t, ".hcount"}, hc, h);
      chk({t, ".vcount"}, vc, v);
      chk({t, ".de"}, de, exp_de(g, pix));
      chk({t, ".hsync"}, hs, exp_hs(g, pix));
      chk({t, ".vsync"}, vs, exp_vs(g, pix));
      chk({t, ".line_start"}, ls, (live == 1 && h == 0) ? 1 : 0);
      chk({t, ".frame_start"}, fs, (live == 1 && h == 0 && v == 0) ? 1 : 0);
      chk({t, ".vblank"}, vb, (rst_n === 1'b1 && v >= g.vres) ? 1 : 0);
   endtask

   // Model: number of enabled pixels since the last reset edge.
   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         pix     = 0;
         started = 1;
      end else if (ce === 1'b1) begin
         pix = pix + 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check_dut("a", ga, int'(hcount_a), int'(vcount_a), int'(de_a), int'(hsync_a),
                   int'(vsync_a), int'(ls_a), int'(fs_a), int'(vb_a));
         check_dut("b", gb, int'(hcount_b), int'(vcount_b), int'(de_b), int'(hsync_b),
                   int'(vsync_b), int'(ls_b), int'(fs_b), int'(vb_b));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int hs_b_first, hs_a_first, de_rise, de_fall, ls_a_first, fs_a_first;
      int fs_b_first, vb_a_first, vs_b_cnt, hs_b_cnt, ls_tog;

      ga = '{A_HRES, A_HFP, A_HSYNC, A_HBP, A_VRES, A_VFP, A_VSYNC, A_VBP, A_LEAD, 0, 0};
      gb = '{B_HRES, B_HFP, B_HSYNC, B_HBP, B_VRES, B_VFP, B_VSYNC, B_VBP, B_LEAD, 1, 1};
      rst_n = 1'b0;
      ce    = 1'b1;

      // Reset state literals.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.hcount_a", int'(hcount_a), 0);
      chk("rst.de_a", int'(de_a), 0);
      chk("rst.hsync_a", int'(hsync_a), 1);
      chk("rst.vsync_a", int'(vsync_a), 1);
      chk("rst.hsync_b", int'(hsync_b), 0);
      chk("rst.vsync_b", int'(vsync_b), 0);
      chk("rst.fs_a", int'(fs_a), 0);
      chk("rst.vblank_b", int'(vb_b), 0);
      rst_n = 1'b1;
      #1;
      chk("release.fs_b", int'(fs_b), 1);

      // Free-running frame with ce=1: measure edges from release.
      hs_b_first = -1; hs_a_first = -1; de_rise = -1; de_fall = -1;
      ls_a_first = -1; fs_a_first = -1; fs_b_first = -1; vb_a_first = -1;
      vs_b_cnt = 0; hs_b_cnt = 0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (hsync_b && hs_b_first < 0) hs_b_first = k;
         if (!hsync_a && hs_a_first < 0) hs_a_first = k;
         if (de_a && de_rise < 0) de_rise = k;
         if (!de_a && de_rise >= 0 && de_fall < 0) de_fall = k;
         if (ls_a && ls_a_first < 0) ls_a_first = k;
         if (fs_a && fs_a_first < 0) fs_a_first = k;
         if (fs_b && fs_b_first < 0) fs_b_first = k;
         if (vb_a && vb_a_first < 0) vb_a_first = k;
         if (k <= 242 && vsync_b) vs_b_cnt++;
         if (k <= 22 && hsync_b) hs_b_cnt++;
      end
      chk("lit.first_hsync_b", hs_b_first, 14);
      chk("lit.first_hsync_a", hs_a_first, 21);
      chk("lit.de_a_rise", de_rise, 3);
      chk("lit.de_a_fall", de_fall, 19);
      chk("lit.line_period_a", ls_a_first, 25);
      chk("lit.frame_period_a", fs_a_first, 275);
      chk("lit.frame_period_b", fs_b_first, 242);
      chk("lit.vblank_a_rise", vb_a_first, 150);
      chk("lit.vsync_b_width", vs_b_cnt, 66);
      chk("lit.hsync_b_width", hs_b_cnt, 4);

      // Pixel enable toggling 1010...: line period doubles.
      apply_reset(2);
      ls_tog = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         ce = (k % 2 == 0) ? 1'b1 : 1'b0;
         #1;
         if (ls_a && ls_tog < 0) ls_tog = k;
      end
      chk("lit.ce_half_line_period_a", ls_tog, 50);
      ce = 1'b1;

      // One-clock reset in the middle of a frame.
      apply_reset(1);
      repeat (120) @(posedge clk);
      #1;
      chk("mid.hcount_a", int'(hcount_a), 20);
      chk("mid.vcount_a", int'(vcount_a), 4);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst.hcount_a", int'(hcount_a), 0);
      chk("midrst.vcount_a", int'(vcount_a), 0);
      chk("midrst.de_a", int'(de_a), 0);
      chk("midrst.hsync_a", int'(hsync_a), 1);
      chk("midrst.vsync_b", int'(vsync_b), 0);
      rst_n = 1'b1;
      #1;
      chk("midrst.fs_a", int'(fs_a), 1);

      // Frame wrap at the last pixel.
      repeat (274) @(posedge clk);
      #1;
      chk("wrap.pre_hcount_a", int'(hcount_a), 24);
      chk("wrap.pre_vcount_a", int'(vcount_a), 10);
      chk("wrap.pre_vblank_a", int'(vb_a), 1);
      @(posedge clk);
      #1;
      chk("wrap.hcount_a", int'(hcount_a), 0);
      chk("wrap.vcount_a", int'(vcount_a), 0);
      chk("wrap.fs_a", int'(fs_a), 1);
      chk("wrap.vblank_a", int'(vb_a), 0);

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
